flow_rate_decoder: RTL
======================

# flow_rate_decoder

Receive-side counterpart of the flow-rate encoder: takes the 5-bit flow code (4-bit flow rate plus even-parity bit) arriving from the sensor link and recovers the 4-bit flow rate. A code is accepted only after it has been stable for a programmable number of cycles, and only if its parity is correct. The block flags and counts corrupt codes and raises a high-flow alarm. It sits between the link input pins and the monitoring/control logic.

## Interface
- STABLE_CYCLES, 3, identical consecutive samples required before a code is evaluated (legal range 1..15)
- ALARM_LEVEL, 4'd12, flow rate at or above which `alarm` asserts
- ERR_CNT_W, 8, width of the saturating parity-error counter

Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- bits_in  in  5  flow code: [3:0] flow rate, [4] = ^bits_in[3:0] (even parity over all 5 bits)
- clr_err  in  1  clears err_count
- flow_rate  out  4  last committed flow rate
- flow_valid  out  1  level, last evaluated code was good
- update  out  1  one-cycle pulse when flow_rate commits a new value
- parity_err  out  1  one-cycle pulse per rejected code
- err_count  out  ERR_CNT_W  saturating count of rejected codes
- alarm  out  1  flow_valid && flow_rate >= ALARM_LEVEL

## Operation
- Input sample register `smp` loads bits_in every edge. The stability counter resets to 0 when a new sample differs from `smp`, otherwise it increments and saturates.
- States:
  - SETTLE: waiting for STABLE_CYCLES identical samples. On reaching the count, evaluate parity:
    - pass → LOCKED;
    - fail → FAULT.
  - LOCKED: code accepted. Any sample change → SETTLE. flow_valid and flow_rate hold meanwhile.
  - FAULT: code rejected. Any sample change → SETTLE.
- Entering LOCKED: flow_rate ← smp[3:0] and flow_valid ← 1. update pulses only if the value differs from the current flow_rate or flow_valid was 0. Re-locking onto the same value gives no pulse.
- Entering FAULT: parity_err pulses, err_count increments (saturates at all-ones), flow_valid ← 0, flow_rate holds its last value, alarm drops.
- A code is evaluated once per stable period. Holding a bad code produces exactly one parity_err.
- clr_err: err_count ← 0 next edge. If clr_err coincides with an increment, the result is 1.
- A glitch shorter than STABLE_CYCLES samples is never evaluated.

## Timing
- Reset (rst_n low at an edge): flow_rate = 0, flow_valid = 0, update = 0, parity_err = 0, err_count = 0, alarm = 0; smp = 0, counter = 0, state = SETTLE. Reset overrides everything, including mid-settle; no update fires from pre-reset samples.
- Latency: if bits_in is stable before edges E1..E_S (S = STABLE_CYCLES), the outputs change at edge E_(S+1). That is S+1 cycles from the input change, and 2 cycles when S = 1.
- alarm is registered alongside flow_rate/flow_valid, so it changes on the same edge.
- update and parity_err are never high in the same cycle.
- After reset with bits_in = 0, code 0 (valid) commits after S+1 cycles.

## Structure
- Shared package `flow_rate_pkg`:
  - FLOW_W = 4 and CODE_W = 5;
  - parity function (`^code`);
  - state encoding SETTLE/LOCKED/FAULT.
  
  The encoder uses the same package.
- One sub-module, `flow_code_stabilizer`: sample register plus stability counter. It outputs `stable_pulse` (one cycle, first time the count is reached) and `changed`.
- FSM, output registers and error counter live in the top.

## Test plan
- Reset, bits_in = 5'b0_0000 held → at the 4th edge: update = 1 for one cycle, flow_rate = 0, flow_valid = 1, alarm = 0.
- bits_in → 5'b1_0010 → flow_rate = 2 and update at the 4th edge after the change. Hold 20 cycles → no further update.
- 5'b1_0100 for 2 cycles, then 5'b0_0101 → 4 is never committed; flow_rate = 5 at the 4th edge after the second change.
- Bad code 5'b0_1000 held 10 cycles → one parity_err, err_count = 1, flow_valid = 0, flow_rate holds 5. Toggle between bad codes 300 times → err_count = 255. Apply clr_err together with a fault → err_count = 1.
- 5'b1_1101 → flow_rate = 13, alarm = 1 on the same edge. Then 5'b0_0110 → alarm = 0 when flow_rate = 6.
- Assert rst_n = 0 two cycles into settling on 5'b1_0111 → all outputs 0 at the next edge. Release with the code still present → commit S+1 cycles after release.

Source files
------------

// File: rtl/flow_rate_pkg.sv
// Shared definitions for the flow-rate encoder/decoder pair: code widths,
// parity helper and the decoder state encoding.
package flow_rate_pkg;

    localparam int unsigned FLOW_W = 4;
    localparam int unsigned CODE_W = 5;

    typedef enum logic [1:0] {
        ST_SETTLE,
        ST_LOCKED,
        ST_FAULT
    } flow_state_t;

    // Even parity over the whole code: a good code folds to 0.
    function automatic logic code_parity(input logic [CODE_W-1:0] code);
        return ^code;
    endfunction

endpackage

// File: rtl/flow_code_stabilizer.sv
// Samples the incoming flow code every edge and reports, once per stable
// period, when the same code has been seen STABLE_CYCLES times in a row.
module flow_code_stabilizer
    import flow_rate_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] bits_in,
    output logic [CODE_W-1:0] smp,
    output logic              stable_pulse,
    output logic              changed
);

    // cnt holds (samples of the current smp value) - 1; the reset value of smp
    // counts as the first sample.
    localparam logic [3:0] TARGET = 4'(STABLE_CYCLES - 1);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            smp     <= '0;
            cnt     <= '0;
            changed <= 1'b0;
        end else begin
            smp     <= bits_in;
            changed <= (bits_in != smp);
            if (bits_in != smp)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + 4'd1;
        end
    end

    // Saturation ceiling sits above every legal TARGET, so equality fires once.
    assign stable_pulse = (cnt == TARGET);

endmodule

// File: rtl/flow_rate_decoder.sv
// Receive-side flow-code decoder: debounces the link code, checks parity,
// commits the flow rate, flags/counts corrupt codes and raises a high-flow alarm.
module flow_rate_decoder
    import flow_rate_pkg::*;
#(
    parameter int unsigned       STABLE_CYCLES = 3,
    parameter logic [FLOW_W-1:0] ALARM_LEVEL   = 4'd12,
    parameter int unsigned       ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CODE_W-1:0]    bits_in,
    input  logic                 clr_err,
    output logic [FLOW_W-1:0]    flow_rate,
    output logic                 flow_valid,
    output logic                 update,
    output logic                 parity_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 alarm
);

    logic [CODE_W-1:0] smp;
    logic              stable_pulse;
    logic              changed;
    flow_state_t       state, next_state;
    logic              accept, reject;

    flow_code_stabilizer #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_stabilizer (
        .clk         (clk),
        .rst_n       (rst_n),
        .bits_in     (bits_in),
        .smp         (smp),
        .stable_pulse(stable_pulse),
        .changed     (changed)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_SETTLE;
        else
            state <= next_state;
    end

    // Evaluation takes priority over a change: with STABLE_CYCLES = 1 both
    // can be seen together and the freshly sampled code must still be judged.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        reject     = 1'b0;
        if (stable_pulse) begin
            if (code_parity(smp) == 1'b0) begin
                accept     = 1'b1;
                next_state = ST_LOCKED;
            end else begin
                reject     = 1'b1;
                next_state = ST_FAULT;
            end
        end else begin
            case (state)
                ST_LOCKED, ST_FAULT: if (changed) next_state = ST_SETTLE;
                default:             next_state = ST_SETTLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flow_rate  <= '0;
            flow_valid <= 1'b0;
            update     <= 1'b0;
            parity_err <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            update     <= 1'b0;
            parity_err <= 1'b0;
            if (accept) begin
                flow_rate  <= smp[FLOW_W-1:0];
                flow_valid <= 1'b1;
                update     <= !flow_valid || (smp[FLOW_W-1:0] != flow_rate);
                alarm      <= (smp[FLOW_W-1:0] >= ALARM_LEVEL);
            end else if (reject) begin
                flow_valid <= 1'b0;
                parity_err <= 1'b1;
                alarm      <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            err_count <= '0;
        else if (clr_err)
            err_count <= reject ? ERR_CNT_W'(1) : '0;
        else if (reject && err_count != '1)
            err_count <= err_count + ERR_CNT_W'(1);
    end

endmodule
